// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// y_red exists only when LOGIC_UNIT_REDUCE_EN is defined.
interface logic_unit_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic [2:0]       y_red;
`endif

    modport master (
        output in_valid, op, a, b, acc_clr, out_ready,
        input  in_ready, out_valid, y, y_zero
`ifdef LOGIC_UNIT_REDUCE_EN
        , input y_red
`endif
    );

    modport slave (
        input  in_valid, op, a, b, acc_clr, out_ready,
        output in_ready, out_valid, y, y_zero
`ifdef LOGIC_UNIT_REDUCE_EN
        , output y_red
`endif
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with running-XOR accumulator and a 2-entry output buffer.
// Define LOGIC_UNIT_REDUCE_EN to store and expose {^r,|r,&r} per buffered result.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    logic_unit_if.slave   bus
);
    localparam logic [2:0] OP_AND  = 3'd0, OP_OR  = 3'd1, OP_NOT  = 3'd2, OP_NAND = 3'd3,
                           OP_NOR  = 3'd4, OP_XOR = 3'd5, OP_XNOR = 3'd6, OP_ACCX = 3'd7;

    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] acc_q, acc_d, acc_base;
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] res;
    logic             push, pop, tail;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic [2:0]       red_q [2];
`endif

    assign push     = bus.in_valid & in_ready_q;
    assign pop      = (count_q != 2'd0) & bus.out_ready;
    // Tail sits one past head when an entry is already held.
    assign tail     = head_q ^ count_q[0];
    assign acc_base = bus.acc_clr ? '0 : acc_q;

    always_comb begin
        res = '0;
        unique case (bus.op)
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_NOT:  res = ~bus.a;
            OP_NAND: res = ~(bus.a & bus.b);
            OP_NOR:  res = ~(bus.a | bus.b);
            OP_XOR:  res = bus.a ^ bus.b;
            OP_XNOR: res = ~(bus.a ^ bus.b);
            OP_ACCX: res = acc_base ^ bus.a;
            default: res = '0;
        endcase
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        head_d  = pop ? ~head_q : head_q;
        acc_d   = (push && bus.op == OP_ACCX) ? res : acc_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            in_ready_q <= 1'b0;
            acc_q      <= '0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
`ifdef LOGIC_UNIT_REDUCE_EN
            red_q[0]   <= 3'b000;
            red_q[1]   <= 3'b000;
`endif
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            in_ready_q <= (count_d < 2'd2);
            acc_q      <= acc_d;
            if (push) begin
                data_q[tail] <= res;
`ifdef LOGIC_UNIT_REDUCE_EN
                red_q[tail]  <= {^res, |res, &res};
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.y         = data_q[head_q];
    assign bus.y_zero    = (data_q[head_q] == '0);
`ifdef LOGIC_UNIT_REDUCE_EN
    assign bus.y_red     = red_q[head_q];
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: ops, accumulator, back-pressure, streaming, reset.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(8)) bus();
    logic_unit_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    logic [7:0] exp_ops [7];
    logic [7:0] exp_acc [3];
    logic [7:0] acc_in  [3];
    logic [7:0] ra, rb;

    initial begin
        exp_ops = '{8'hA0, 8'hFA, 8'h0F, 8'h5F, 8'h05, 8'h5A, 8'hA5};
        acc_in  = '{8'h01, 8'h02, 8'h04};
        exp_acc = '{8'h01, 8'h03, 8'h07};
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_y", bus.y, 8'h00);
        chk("rst_y_zero", bus.y_zero, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1'b1);

        // Opcodes 0..6, streamed back to back
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3'(i), 8'hF0, 8'hAA);
            @(negedge clk);
            chk($sformatf("op%0d_valid", i), bus.out_valid, 1'b1);
            chk($sformatf("op%0d_y", i), bus.y, exp_ops[i]);
            chk($sformatf("op%0d_in_ready", i), bus.in_ready, 1'b1);
        end
        drive(1'b1, 3'd0, 8'hF0, 8'h0F);
        @(negedge clk);
        chk("and_zero_y", bus.y, 8'h00);
        chk("and_zero_flag", bus.y_zero, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("drain_out_valid", bus.out_valid, 1'b0);

        // Accumulator
        bus.acc_clr = 1'b1;
        @(negedge clk);
        bus.acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd7, acc_in[i], 8'hFF);
            @(negedge clk);
            chk($sformatf("accx%0d_y", i), bus.y, exp_acc[i]);
        end
        drive(1'b1, 3'd5, 8'h55, 8'h0F);
        @(negedge clk);
        chk("xor_between_accx", bus.y, 8'h5A);
        drive(1'b1, 3'd7, 8'h10, 8'h00);
        @(negedge clk);
        chk("accx_after_xor", bus.y, 8'h17);
        bus.acc_clr = 1'b1;
        drive(1'b1, 3'd7, 8'h10, 8'h00);
        @(negedge clk);
        chk("accx_with_clr", bus.y, 8'h10);
        bus.acc_clr = 1'b0;
        drive(1'b1, 3'd7, 8'h01, 8'h00);
        @(negedge clk);
        chk("accx_after_clr", bus.y, 8'h11);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);

        // Back-pressure: third beat must wait
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 8'hFF, 8'h0F);
        @(negedge clk);
        chk("bp_first_y", bus.y, 8'h0F);
        chk("bp_first_in_ready", bus.in_ready, 1'b1);
        drive(1'b1, 3'd1, 8'h30, 8'h03);
        @(negedge clk);
        chk("bp_full_in_ready", bus.in_ready, 1'b0);
        chk("bp_full_y", bus.y, 8'h0F);
        drive(1'b1, 3'd5, 8'hFF, 8'h0F);
        @(negedge clk);
        chk("bp_hold_y", bus.y, 8'h0F);
        chk("bp_hold_valid", bus.out_valid, 1'b1);
        chk("bp_hold_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_y", bus.y, 8'h33);
        chk("bp_reopen_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("bp_third_y", bus.y, 8'hF0);
        chk("bp_third_valid", bus.out_valid, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("bp_drained", bus.out_valid, 1'b0);

        // Streaming random XOR beats at one per clock
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive(1'b1, 3'd5, ra, rb);
            @(negedge clk);
            chk($sformatf("stream%0d_y", i), {bus.out_valid, bus.in_ready, bus.y}, {1'b1, 1'b1, ra ^ rb});
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);

        // Reset with two entries buffered
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h0F, 8'hF0);
        repeat (2) @(negedge clk);
        chk("pre_rst_full", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_y", bus.y, 8'h00);
        chk("mid_rst_y_zero", bus.y_zero, 1'b1);
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'd7, 8'h3C, 8'h00);
        @(negedge clk);
        chk("post_rst_accx", bus.y, 8'h3C);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);

`ifdef LOGIC_UNIT_REDUCE_EN
        drive(1'b1, 3'd1, 8'hF0, 8'h0F);
        @(negedge clk);
        chk("red_ff", bus.y_red, 3'b011);
        drive(1'b1, 3'd0, 8'h01, 8'h01);
        @(negedge clk);
        chk("red_01", bus.y_red, 3'b110);
        drive(1'b1, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("red_00", bus.y_red, 3'b000);
        chk("red_00_zero", bus.y_zero, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
